nes_joypad_reader: RTL
======================

// Module: nes_joypad_reader
// PURPOSE
// Initiator side of the NES controller serial protocol: drives latch/clock pins to real NES-style pads
// and shifts in their serial data. Produces per-pad active-high button bytes in the core's joypad order
// {right,left,down,up,start,select,b,a}, plus a presence flag. Sits between cartridge-port/link pins and
// the input mux that feeds the core's joypad shift register. Runs in the PPU clock domain (21.47 MHz).
// PARAMETERS
// NUM_PADS     2    number of pads sharing latch/clock; one data line each
// TICK_DIV     129  clk cycles per protocol tick (~6.0 us at 21.47 MHz); must be >= 2
// LATCH_TICKS  2    ticks latch is held high
// POLL_TICKS   2778 ticks between automatic polls (~16.7 ms); 0 disables auto-poll
// PORTS
// clk          in   1            core clock
// reset        in   1            asynchronous, active-high
// poll_req     in   1            one-cycle request to start a transaction
// pad_data     in   NUM_PADS     raw serial data pins, low = pressed; asynchronous to clk
// pad_latch    out  1            latch pin, high = load pad shift register
// pad_clk      out  1            clock pin, idle high; pad shifts on rising edge
// buttons      out  8*NUM_PADS   pad n at [8n+7:8n], bit0=A ... bit7=right, 1 = pressed
// present      out  NUM_PADS     1 = pad detected on last completed poll
// valid        out  1            one-cycle pulse when buttons/present update
// busy         out  1            high from accepted request until the valid pulse
// BEHAVIOUR
// - Reset values: pad_latch=0, pad_clk=1, buttons=0, present=0, valid=0, busy=0; FSM=IDLE; counters 0.
// - pad_data passes through a 2-flop synchronizer; all sampling uses the synchronized value.
// - Tick: prescaler counts 0..TICK_DIV-1, free-running from reset; tick=1 for one clk at wrap.
// - Start: poll_req, or auto-poll counter reaching POLL_TICKS-1 on a tick, while IDLE. Simultaneous
//   sources start one transaction. Requests while busy are dropped (not queued). Auto counter
//   restarts at 0 on every start.
// - FSM (advances only on tick except IDLE->LATCH):
//   IDLE: latch=0, clk=1. On start -> LATCH, busy=1 next cycle.
//   LATCH: latch=1 for LATCH_TICKS ticks -> SETTLE.
//   SETTLE: latch=0 for 1 tick; on exit sample bit 0 -> CLK_LO.
//   CLK_LO: clk=0 for 1 tick -> CLK_HI.
//   CLK_HI: clk=1 for 1 tick; on exit sample next bit; after 16 bits total sampled -> DONE else CLK_LO.
//   DONE: one clk: commit, valid=1, busy=0 -> IDLE.
// - Bit k (0..7) of pad n: buttons[8n+k] = ~sync(pad_data[n]) at that sample.
// - Bits 8..15 are presence bits: official pad drives low after its 8 bits; open pin floats high.
//   present[n]=1 iff all 8 presence samples low. If present[n]=0, buttons for pad n commit as 0.
// - Commit is atomic: staging registers shifted during transaction; buttons/present change only in DONE.
//   Outside DONE outputs hold last committed value.
// - Transaction length: (LATCH_TICKS + 1 + 2*15) ticks + 2 clk overhead; defaults 33 ticks.
// - Asynchronous reset mid-transaction: pins return to idle levels immediately, staging discarded,
//   no valid pulse.
// - Counter widths: $clog2 of bound+1; bit counter 5 bits; no wrap beyond stated bounds.
// STRUCTURE
// - Package nes_joy_pkg: state enum (IDLE,LATCH,SETTLE,CLK_LO,CLK_HI,DONE), BTN_A..BTN_RIGHT index
//   constants, PAD_BITS=8, PRESENCE_BITS=8.
// - Sub-module joy_tick_gen: prescaler producing tick; parameter TICK_DIV. Synchronizer and FSM inline.
// TESTING
// - Pad model (4021 behaviour, low=pressed, presence bits low), NUM_PADS=2, TICK_DIV=4, auto off.
// - Pad0 pressed A+start (wire 0,1,1,0,1,1,1,1), pad1 none; poll_req -> valid once, buttons=16'h0009,
//   present=2'b11, latch high exactly 8 clk, 15 pad_clk low pulses of 4 clk each.
// - Pad1 data pin tied high (absent), pad0 right pressed -> present=2'b01, buttons=16'h0080.
// - poll_req pulses every cycle during busy -> exactly one valid per transaction; busy low 1 clk then
//   next accepted.
// - Auto-poll POLL_TICKS=50 -> valid every 50 ticks (200 clk); poll_req on same cycle as auto start ->
//   single transaction.
// - Reset asserted during CLK_LO of bit 5 -> pad_clk=1, pad_latch=0 same cycle, buttons=0, no valid;
//   next poll returns correct values.
// - Pad changes between polls: buttons hold old value until DONE of next poll, never partial.

Source files
------------

// File: rtl/nes_joy_pkg.sv
// Shared types and constants for the NES joypad reader: FSM states and button bit positions.
package nes_joy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SETTLE,
    CLK_LO,
    CLK_HI,
    DONE
  } joy_state_e;

  localparam int unsigned PAD_BITS      = 8;
  localparam int unsigned PRESENCE_BITS = 8;
  localparam int unsigned SAMPLE_BITS   = PAD_BITS + PRESENCE_BITS;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

endpackage

// File: rtl/nes_joypad_reader_if.sv
// Core-side request/result bundle of the joypad reader; the reader uses the slave modport.
interface nes_joypad_reader_if #(
  parameter int unsigned NUM_PADS = 2
);
  logic                  poll_req;
  logic [8*NUM_PADS-1:0] buttons;
  logic [NUM_PADS-1:0]   present;
  logic                  valid;
  logic                  busy;

  modport master (output poll_req, input buttons, input present, input valid, input busy);
  modport slave  (input poll_req, output buttons, output present, output valid, output busy);
endinterface

// File: rtl/joy_tick_gen.sv
// Free-running prescaler: tick_o is high for one clk each time the count wraps.
module joy_tick_gen #(
  parameter int unsigned TICK_DIV = 129
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);
  localparam int unsigned CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == CW'(TICK_DIV - 1));
    cnt_d  = tick_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/nes_joypad_reader.sv
// NES controller initiator: drives latch/clock pins, shifts in 16 bits per pad, commits button
// bytes and presence flags atomically at the end of each poll.
module nes_joypad_reader
  import nes_joy_pkg::*;
#(
  parameter int unsigned NUM_PADS    = 2,
  parameter int unsigned TICK_DIV    = 129,
  parameter int unsigned LATCH_TICKS = 2,
  parameter int unsigned POLL_TICKS  = 2778
) (
  input  logic                clk,
  input  logic                reset,
  nes_joypad_reader_if.slave  joy,
  input  logic [NUM_PADS-1:0] pad_data,
  output logic                pad_latch,
  output logic                pad_clk
);
  localparam int unsigned LATCH_LAST = (LATCH_TICKS > 0) ? LATCH_TICKS - 1 : 0;
  localparam int unsigned LW         = (LATCH_LAST > 0) ? $clog2(LATCH_LAST + 1) : 1;
  localparam bit          AUTO_EN    = (POLL_TICKS != 0);
  localparam int unsigned POLL_LAST  = AUTO_EN ? POLL_TICKS - 1 : 0;
  localparam int unsigned PW         = (POLL_LAST > 0) ? $clog2(POLL_LAST + 1) : 1;

  joy_state_e                           state_q, state_d;
  logic [LW-1:0]                        lat_cnt_q, lat_cnt_d;
  logic [4:0]                           bit_q, bit_d;
  logic [PW-1:0]                        poll_cnt_q, poll_cnt_d;
  logic [NUM_PADS-1:0]                  sync1_q, sync2_q;
  logic [NUM_PADS-1:0][SAMPLE_BITS-1:0] shift_q, shift_d;
  logic [PAD_BITS*NUM_PADS-1:0]         buttons_q, buttons_d;
  logic [NUM_PADS-1:0]                  present_q, present_d;
  logic                                 valid_q, valid_d;
  logic                                 busy_q, busy_d;
  logic                                 pad_latch_q, pad_clk_q;
  logic                                 tick, auto_fire, start, sample;

  joy_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick)
  );

  always_comb begin
    auto_fire  = AUTO_EN && tick && (poll_cnt_q == PW'(POLL_LAST));
    start      = (state_q == IDLE) && (joy.poll_req || auto_fire);
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    buttons_d  = buttons_q;
    present_d  = present_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    sample     = 1'b0;
    poll_cnt_d = poll_cnt_q;

    // Auto-poll counter saturates at its bound until a transaction actually starts.
    if (start)                                     poll_cnt_d = '0;
    else if (tick && poll_cnt_q != PW'(POLL_LAST)) poll_cnt_d = poll_cnt_q + PW'(1);

    unique case (state_q)
      IDLE: if (start) begin
        state_d   = LATCH;
        busy_d    = 1'b1;
        lat_cnt_d = '0;
        bit_d     = '0;
      end
      LATCH: if (tick) begin
        if (lat_cnt_q == LW'(LATCH_LAST)) state_d = SETTLE;
        else                              lat_cnt_d = lat_cnt_q + LW'(1);
      end
      SETTLE: if (tick) begin
        sample  = 1'b1;
        state_d = CLK_LO;
      end
      CLK_LO: if (tick) state_d = CLK_HI;
      CLK_HI: if (tick) begin
        sample  = 1'b1;
        state_d = (bit_q == 5'(SAMPLE_BITS - 1)) ? DONE : CLK_LO;
      end
      DONE: begin
        for (int unsigned n = 0; n < NUM_PADS; n++) begin
          present_d[n] = (shift_q[n][SAMPLE_BITS-1:PAD_BITS] == '0);
          buttons_d[n*PAD_BITS +: PAD_BITS] = present_d[n] ? ~shift_q[n][PAD_BITS-1:0] : '0;
        end
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Samples enter at the top so bit k lands at index k after all 16 shifts.
    if (sample) begin
      bit_d = bit_q + 5'd1;
      for (int unsigned n = 0; n < NUM_PADS; n++)
        shift_d[n] = {sync2_q[n], shift_q[n][SAMPLE_BITS-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      bit_q       <= '0;
      poll_cnt_q  <= '0;
      sync1_q     <= '1;
      sync2_q     <= '1;
      shift_q     <= '0;
      buttons_q   <= '0;
      present_q   <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      bit_q       <= bit_d;
      poll_cnt_q  <= poll_cnt_d;
      sync1_q     <= pad_data;
      sync2_q     <= sync1_q;
      shift_q     <= shift_d;
      buttons_q   <= buttons_d;
      present_q   <= present_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      pad_latch_q <= (state_d == LATCH);
      pad_clk_q   <= (state_d != CLK_LO);
    end
  end

  assign pad_latch   = pad_latch_q;
  assign pad_clk     = pad_clk_q;
  assign joy.buttons = buttons_q;
  assign joy.present = present_q;
  assign joy.valid   = valid_q;
  assign joy.busy    = busy_q;
endmodule
